// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, FSM states and instruction field positions for multicycle_cpu
package cpu_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LW   = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam int OP_LSB  = 28;
  localparam int RD_LSB  = 24;
  localparam int RS_LSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int IMM_W   = 16;
  // Opcodes B..E are the only illegal ones
  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_JMP || op == OP_HALT;
  endfunction
endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile: NREGS x DATA_W register file, two async reads, one sync write, r0 reads as zero
module cpu_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS = 8,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     ra,
  input  logic [AW-1:0]     rb,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b
);
  logic [DATA_W-1:0] regs [NREGS];
  // Write port; writes to r0 are dropped so it stays zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) regs <= '{default: '0};
    else if (we && wa != '0) regs[wa] <= wd;
  assign a = ra == '0 ? '0 : regs[ra];
  assign b = rb == '0 ? '0 : regs[rb];
endmodule

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: FETCH/DECODE/EXEC/MEM/WB core with req/ready ROM and RAM ports
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int NREGS = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_req,
  input  logic              rom_ready,
  input  logic [31:0]       rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_req,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output logic              halted,
  output logic              illegal,
  output logic [31:0]       retired
);
  localparam int RW = $clog2(NREGS);
  state_t state;
  logic [31:0] ir;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] res_q, rf_a, rf_b, alu;
  logic [3:0] op;
  logic [DATA_W-1:0] imm_d;
  logic [ADDR_W-1:0] imm_a, pc_inc;
  logic unused_bits;
  assign op = ir[OP_LSB +: 4];
  assign imm_d = DATA_W'($signed(ir[IMM_W-1:0]));
  assign imm_a = ADDR_W'($signed(ir[IMM_W-1:0]));
  assign pc_inc = pc + ADDR_W'(1);
  assign unused_bits = ^{ir[27:16], res_q};
  cpu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
    .clk(clk),
    .reset(reset),
    .ra(ir[RS_LSB +: RW]),
    .rb(ir[RT_LSB +: RW]),
    .we(state == WB),
    .wa(ir[RD_LSB +: RW]),
    .wd(res_q),
    .a(rf_a),
    .b(rf_b)
  );
  // ALU; the fall-through add serves ADDI and the LW/SW effective address
  always_comb
    alu = op == OP_ADD ? rf_a + rf_b :
          op == OP_SUB ? rf_a - rf_b :
          op == OP_AND ? rf_a & rf_b :
          op == OP_OR  ? rf_a | rf_b :
          op == OP_XOR ? rf_a ^ rf_b : rf_a + imm_d;
  // Control FSM with PC, result latch, retired counter and sticky illegal flag
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      ir <= '0;
      res_q <= '0;
      retired <= '0;
      illegal <= 1'b0;
    end else
      case (state)
        FETCH: if (rom_ready) begin
          ir <= rom_data;
          state <= DECODE;
        end
        DECODE: if (!is_legal(op)) begin
          illegal <= 1'b1;
          state <= HALT;
        end else if (op == OP_HALT) begin
          retired <= retired + 32'd1;
          state <= HALT;
        end else state <= EXEC;
        EXEC: begin
          res_q <= alu;
          if (op == OP_LW || op == OP_SW) state <= MEM;
          else if (op == OP_BEQ || op == OP_JMP || op == OP_NOP) begin
            pc <= op == OP_JMP ? imm_a : (op == OP_BEQ && rf_a == rf_b) ? pc_inc + imm_a : pc_inc;
            retired <= retired + 32'd1;
            state <= FETCH;
          end else state <= WB;
        end
        MEM: if (ram_ready) begin
          if (op == OP_LW) begin
            res_q <= ram_rdata;
            state <= WB;
          end else begin
            pc <= pc_inc;
            retired <= retired + 32'd1;
            state <= FETCH;
          end
        end
        WB: begin
          pc <= pc_inc;
          retired <= retired + 32'd1;
          state <= FETCH;
        end
        default: ;
      endcase
  // Requests are gated by reset so they drop the instant reset asserts
  assign rom_req = reset && state == FETCH;
  assign ram_req = reset && state == MEM;
  assign ram_wren = ram_req && op == OP_SW;
  assign rom_addr = pc;
  assign ram_addr = ADDR_W'(res_q);
  assign ram_wdata = rf_b;
  assign halted = state == HALT;
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: table-driven and directed checks of multicycle_cpu with ROM/RAM models and a RAM access scoreboard
module tb_multicycle_cpu;
  localparam int DW = 32;
  localparam int AW = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [AW-1:0] rom_addr, ram_addr;
  logic rom_req, rom_ready, ram_req, ram_wren, ram_ready, halted, illegal;
  logic [31:0] rom_data, retired;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic [31:0] rom [256];
  logic [DW-1:0] ram [256];
  int rom_dly = 0, ram_dly = 0, rom_cnt, ram_cnt, cyc;
  int n_cmp = 0, n_bad = 0;
  int stab_err, ram_reqs;
  logic rom_wait, ram_wait, ram_wren_prev;
  logic [AW-1:0] rom_a_prev, ram_a_prev;
  logic [DW-1:0] ram_d_prev;
  typedef struct {logic [AW-1:0] addr; logic wren; logic [DW-1:0] data;} acc_t;
  typedef struct {logic [AW-1:0] addr; int cyc;} fetch_t;
  typedef struct {logic [3:0] op; logic [15:0] a; logic [15:0] b; logic [DW-1:0] exp;} vec_t;
  acc_t exp_q[$];
  fetch_t fetch_log[$];

  always #5 clk = ~clk;

  multicycle_cpu #(.DATA_W(DW), .ADDR_W(AW), .NREGS(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset),
    .rom_addr(rom_addr), .rom_req(rom_req), .rom_ready(rom_ready), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_req(ram_req), .ram_wren(ram_wren), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  assign rom_data = rom[rom_addr];
  assign rom_ready = rom_req && rom_cnt >= rom_dly;
  assign ram_rdata = ram[ram_addr];
  assign ram_ready = ram_req && ram_cnt >= ram_dly;

  // Memory models: ready after a programmable number of wait cycles
  always @(posedge clk or negedge reset)
    if (!reset) begin
      rom_cnt <= 0;
      ram_cnt <= 0;
      cyc <= 0;
      for (int i = 0; i < 256; i++) ram[i] <= 32'hA5A5_0000 | i;
    end else begin
      cyc <= cyc + 1;
      rom_cnt <= (rom_req && !rom_ready) ? rom_cnt + 1 : 0;
      ram_cnt <= (ram_req && !ram_ready) ? ram_cnt + 1 : 0;
      if (ram_req && ram_wren && ram_ready) ram[ram_addr] <= ram_wdata;
    end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor away from the clock edge: hold stability, fetch log, RAM scoreboard
  always @(negedge clk)
    if (!reset) begin
      stab_err <= 0;
      ram_reqs <= 0;
      rom_wait <= 1'b0;
      ram_wait <= 1'b0;
      fetch_log.delete();
    end else begin
      stab_err <= stab_err + int'(rom_req && rom_wait && rom_addr != rom_a_prev)
                + int'(ram_req && ram_wait && (ram_addr != ram_a_prev || ram_wren != ram_wren_prev || ram_wdata != ram_d_prev));
      rom_wait <= rom_req && !rom_ready;
      rom_a_prev <= rom_addr;
      ram_wait <= ram_req && !ram_ready;
      ram_a_prev <= ram_addr;
      ram_wren_prev <= ram_wren;
      ram_d_prev <= ram_wdata;
      if (ram_req) ram_reqs <= ram_reqs + 1;
      if (rom_req && rom_ready) fetch_log.push_back('{rom_addr, cyc});
      if (ram_req && ram_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL ram_unexpected: got access at %0h wren %0b, required none", ram_addr, ram_wren);
        end else begin
          check("ram_addr", ram_addr, exp_q[0].addr);
          check("ram_wren", ram_wren, exp_q[0].wren);
          check("ram_data", ram_wren ? ram_wdata : ram_rdata, exp_q[0].data);
          void'(exp_q.pop_front());
        end
      end
    end

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                                      input logic [3:0] rt, input logic [15:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_halt(input int budget, output int n);
    n = 0;
    while (!halted && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!halted) begin
      n_cmp++;
      n_bad++;
      $display("FAIL halt_timeout: got halted=0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic load_basic();
    clear_rom();
    rom[0] = enc(4'h6, 1, 0, 0, 16'd5);
    rom[1] = enc(4'h6, 2, 0, 0, 16'd7);
    rom[2] = enc(4'h1, 3, 1, 2, 16'd0);
    rom[3] = enc(4'hF, 0, 0, 0, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int n, k, fl;
    vecs[0] = '{4'h1, 16'd5, 16'd7, 32'd12};
    vecs[1] = '{4'h2, 16'd5, 16'd7, 32'hFFFF_FFFE};
    vecs[2] = '{4'h3, 16'h0F0F, 16'h00FF, 32'h0000_000F};
    vecs[3] = '{4'h4, 16'h0F00, 16'h00F0, 32'h0000_0FF0};
    vecs[4] = '{4'h5, 16'hFFFF, 16'h1234, 32'hFFFF_EDCB};
    vecs[5] = '{4'h1, 16'hFFFF, 16'h0001, 32'h0};
    vecs[6] = '{4'h2, 16'h8000, 16'h0001, 32'hFFFF_7FFF};

    // Reset values and the basic program with ROM ready tied high
    load_basic();
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_rom_req", rom_req, 0);
    check("rst_ram_req", ram_req, 0);
    check("rst_ram_wren", ram_wren, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    check("rst_retired", retired, 0);
    check("rst_rom_addr", rom_addr, 0);
    @(negedge clk);
    reset = 1'b1;
    run_halt(200, n);
    check("basic_cycles", n, 14);
    check("basic_r3", dut.u_rf.regs[3], 12);
    check("basic_retired", retired, 4);
    check("basic_halted", halted, 1);
    check("basic_no_ram", ram_reqs, 0);
    check("basic_rom_req_off", rom_req, 0);

    // Same program with three ROM wait cycles per fetch
    rom_dly = 3;
    do_reset();
    run_halt(200, n);
    check("slow_rom_cycles", n, 26);
    check("slow_rom_stable", stab_err, 0);
    check("slow_rom_r3", dut.u_rf.regs[3], 12);
    check("slow_rom_retired", retired, 4);
    rom_dly = 0;

    // ALU table: results leave the core through a store checked by the scoreboard
    foreach (vecs[i]) begin
      clear_rom();
      rom[0] = enc(4'h6, 1, 0, 0, vecs[i].a);
      rom[1] = enc(4'h6, 2, 0, 0, vecs[i].b);
      rom[2] = enc(vecs[i].op, 3, 1, 2, 16'd0);
      rom[3] = enc(4'h8, 0, 0, 3, 16'h10 + 16'(i));
      rom[4] = enc(4'hF, 0, 0, 0, 16'd0);
      exp_q.delete();
      exp_q.push_back('{8'h10 + 8'(i), 1'b1, vecs[i].exp});
      do_reset();
      run_halt(200, n);
      check("alu_cycles", n, 18);
      check("alu_retired", retired, 5);
      check("alu_sb_drain", exp_q.size(), 0);
    end

    // Store/load round trip with a slow RAM, plus a discarded write to r0
    ram_dly = 2;
    load_basic();
    rom[3] = enc(4'h8, 0, 0, 3, 16'd8);
    rom[4] = enc(4'h7, 4, 0, 0, 16'd8);
    rom[5] = enc(4'h8, 0, 0, 4, 16'd9);
    rom[6] = enc(4'h6, 0, 0, 0, 16'd9);
    rom[7] = enc(4'h8, 0, 0, 0, 16'd10);
    rom[8] = enc(4'h7, 5, 1, 0, 16'd4);
    rom[9] = enc(4'hF, 0, 0, 0, 16'd0);
    exp_q.delete();
    exp_q.push_back('{8'd8, 1'b1, 32'd12});
    exp_q.push_back('{8'd8, 1'b0, 32'd12});
    exp_q.push_back('{8'd9, 1'b1, 32'd12});
    exp_q.push_back('{8'd10, 1'b1, 32'd0});
    exp_q.push_back('{8'd9, 1'b0, 32'd12});
    do_reset();
    run_halt(400, n);
    check("mem_sb_drain", exp_q.size(), 0);
    check("mem_stable", stab_err, 0);
    check("mem_retired", retired, 10);
    ram_dly = 0;

    // BEQ r0,r0,-1 at 0x05 spins with a 3-cycle fetch period
    clear_rom();
    rom[5] = enc(4'h9, 0, 0, 0, 16'hFFFF);
    do_reset();
    repeat (40) @(posedge clk);
    #1;
    if (fetch_log.size() < 10) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beq_fetches: got %0d fetches, required at least 10", fetch_log.size());
    end else begin
      for (int i = 1; i < 10; i++) check("beq_period", fetch_log[i].cyc - fetch_log[i-1].cyc, 3);
      for (int i = 5; i < 10; i++) check("beq_addr", fetch_log[i].addr, 8'h05);
    end

    // JMP 0xFF then NOP wraps the PC back to 0x00
    clear_rom();
    rom[0] = enc(4'hA, 0, 0, 0, 16'h00FF);
    do_reset();
    repeat (8) @(posedge clk);
    #1;
    if (fetch_log.size() < 3) begin
      n_cmp++;
      n_bad++;
      $display("FAIL jmp_fetches: got %0d fetches, required at least 3", fetch_log.size());
    end else begin
      check("jmp_target", fetch_log[1].addr, 8'hFF);
      check("jmp_wrap", fetch_log[2].addr, 8'h00);
      check("jmp_wrap_cyc", fetch_log[2].cyc, 6);
    end

    // Illegal opcode stops the core without retiring
    clear_rom();
    rom[0] = enc(4'h6, 1, 0, 0, 16'd1);
    rom[1] = 32'hC000_0000;
    do_reset();
    run_halt(100, n);
    check("ill_cycles", n, 6);
    check("ill_flag", illegal, 1);
    check("ill_halted", halted, 1);
    check("ill_retired", retired, 1);
    fl = fetch_log.size();
    repeat (5) @(posedge clk);
    #1;
    check("ill_no_fetch", fetch_log.size(), fl);
    check("ill_rom_req", rom_req, 0);
    check("ill_sticky", illegal, 1);

    // Reset in the middle of a stalled store
    ram_dly = 50;
    clear_rom();
    rom[0] = enc(4'h6, 1, 0, 0, 16'd1);
    rom[1] = enc(4'h8, 0, 0, 1, 16'd0);
    exp_q.delete();
    do_reset();
    k = 0;
    while (!ram_req && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("mid_reached_mem", ram_req, 1);
    check("mid_retired_pre", retired, 1);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("mid_ram_req_drop", ram_req, 0);
    check("mid_ram_wren_drop", ram_wren, 0);
    check("mid_rom_req_off", rom_req, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_refetch_req", rom_req, 1);
    check("mid_refetch_addr", rom_addr, 0);
    check("mid_retired", retired, 0);
    check("mid_ram0_kept", ram[0], 32'hA5A5_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_cpu.md
Name: multicycle_cpu

Overview:
- Parametrised multicycle CPU core. Fetches 32-bit instructions from the program ROM and loads/stores data in the RAM.
- Uses req/ready handshakes on both memory ports. UC-gated memory clocks (clk_ram/clk_rom) are not used; the ROM and RAM run on clk.
- Sits directly under the top level, between the ROM and RAM instances.
- Contains the control FSM, ALU, register file, PC and a retired-instruction counter.

Parameters:
- DATA_W, 32: datapath, register and RAM word width (8..32).
- ADDR_W, 8: ROM and RAM address width.
- NREGS, 8: register count, power of 2, 2..16. r0 always reads as 0.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rom_addr  out  ADDR_W  instruction address (equals PC).
- rom_req  out  1  instruction fetch request.
- rom_ready  in  1  rom_data valid this cycle.
- rom_data  in  32  instruction word.
- ram_addr  out  ADDR_W  data address.
- ram_req  out  1  data access request.
- ram_wren  out  1  1 = store, 0 = load; meaningful only while ram_req=1.
- ram_wdata  out  DATA_W  store data.
- ram_rdata  in  DATA_W  load data.
- ram_ready  in  1  access complete; ram_rdata valid for loads.
- halted  out  1  core stopped (HALT or illegal opcode).
- illegal  out  1  sticky; set when an illegal opcode is decoded.
- retired  out  32  retired-instruction count; wraps modulo 2^32.

Behaviour:
- Encoding: [31:28] op, [27:24] rd, [23:20] rs, [19:16] rt, [15:0] imm.
  - Register fields use their low log2(NREGS) bits.
  - imm is sign-extended to DATA_W, or truncated when DATA_W<16.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd = rs op rt.
  - 6 ADDI: rd = rs + imm.
  - 7 LW: rd = RAM[ea]. 8 SW: RAM[ea] = rt. ea = low ADDR_W bits of (rs + imm).
  - 9 BEQ: if rs==rt then PC = PC+1+imm[ADDR_W-1:0].
  - A JMP: PC = imm[ADDR_W-1:0].
  - F HALT.
  - B..E illegal.
- Arithmetic is modulo 2^DATA_W. PC arithmetic is modulo 2^ADDR_W, so it wraps from 2^ADDR_W-1 to 0.
- Writes to r0 are discarded.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: rom_req=1, held until rom_ready. On rom_ready, latch the instruction, then go to DECODE.
  - DECODE: read rs/rt and classify the opcode.
    - Illegal opcode: set illegal, go to HALT.
    - HALT opcode: go to HALT.
  - EXEC: ALU operation or ea computation.
    - BEQ/JMP/NOP: update PC, retired+1, go to FETCH.
    - LW/SW: go to MEM.
    - All other opcodes: go to WB.
  - MEM: ram_req=1, with ram_addr, ram_wren and ram_wdata held stable until ram_ready.
    - SW: on ram_ready, PC+1, retired+1, go to FETCH.
    - LW: on ram_ready, latch ram_rdata, go to WB.
  - WB: write rd, PC+1, retired+1, go to FETCH.
  - HALT: absorbing; left only by reset. halted=1, rom_req=0, ram_req=0. HALT itself counts as retired.
- Minimum latency with ready returned in the same cycle as req:
  - ALU op: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch/JMP/NOP: 3 cycles.
- A request is held for as many cycles as ready stays low; there is no timeout.
- ready inputs are ignored outside their own request state.
- Reset values:
  - PC = RESET_PC; FSM state = FETCH.
  - All registers 0; retired = 0; illegal = 0; halted = 0.
  - rom_req, ram_req and ram_wren are 0 while reset is asserted. rom_addr = RESET_PC.
- Reset mid-transaction: requests drop asynchronously, and any pending write is abandoned. The first request after reset deassertion is a FETCH from RESET_PC in the first clock edge's cycle.
- BEQ is taken as a branch when rs=rt=r0.

Decomposition:
- Package cpu_pkg: opcode constants, the state enum, and field-position constants.
- Sub-module cpu_regfile: NREGS x DATA_W, two asynchronous read ports, one synchronous write port, r0 hardwired to zero.
- The ALU stays inline.

Test Plan:
- Reset release, ROM ready tied to 1, program ADDI r1,r0,5 / ADDI r2,r0,7 / ADD r3,r1,r2 / HALT
  -> r3=12, retired=4, halted=1 at cycle 14, no ram_req.
- ROM ready delayed 3 cycles per fetch
  -> rom_req and rom_addr held stable; total cycles for the same program grow by exactly 12.
- SW r3,8(r0) then LW r4,8(r0), RAM model with 2-cycle ready
  -> ram_addr=8, ram_wren=1, ram_wdata=12, then r4=12.
- BEQ r0,r0,-1 at PC=0x05
  -> rom_addr returns to 0x05 every 3 cycles. JMP 0xFF followed by NOP -> next fetch at 0x00 (wrap).
- Opcode 0xC fetched
  -> illegal=1, halted=1, retired unchanged, no further rom_req.
- reset asserted while ram_req=1 in MEM
  -> ram_req=0 immediately; after release, first fetch at RESET_PC with retired=0.
